// File: rtl/captura_hex_display_pkg.sv
// captura_pkg: shared FSM state type, default key codes and hex segment table
package captura_pkg;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;
  localparam logic [3:0] CLEAR_DEF = 4'hE;
  localparam logic [3:0] ENTER_DEF = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low {g,f,e,d,c,b,a}, entry 15 (F) first down to entry 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/captura_hex_display_hex_a_7seg.sv
// hex_a_7seg: combinational hex nibble to active-low 7-segment pattern
module hex_a_7seg
  import captura_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/captura_hex_display.sv
// captura_hex_display: keypad entry buffer with commit/clear and multiplexed hex display
module captura_hex_display
  import captura_pkg::*;
#(
  parameter int         SCAN_DIV   = 50000,
  parameter logic [3:0] CLEAR_CODE = CLEAR_DEF,
  parameter logic [3:0] ENTER_CODE = ENTER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [2:0]  digit_count,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  state_t      state_q;
  logic [15:0] buf_q, value_q;
  logic        vv_q;
  logic [2:0]  cnt_q;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d, nib;
  logic [6:0]  seg_q, seg_d, hex_seg;
  logic        wrap, lit;
  // Entry FSM: digits shift in from the right, enter commits, clear discards
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
    end else begin
      vv_q <= 1'b0;
      if (key_valid) begin
        if (key_code == CLEAR_CODE) begin
          state_q <= EMPTY;
          buf_q   <= '0;
          cnt_q   <= '0;
        end else if (key_code == ENTER_CODE) begin
          if (state_q != EMPTY) begin
            value_q <= buf_q;
            vv_q    <= 1'b1;
            state_q <= EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
          end
        end else if (state_q != FULL) begin
          buf_q   <= {buf_q[11:0], key_code};
          cnt_q   <= cnt_q + 3'd1;
          state_q <= (cnt_q == 3'd3) ? FULL : ENTRY;
        end
      end
    end
  end
  // Scan divider and digit selection; digit i is lit only while it holds a typed nibble
  always_comb begin
    wrap   = (scan_q == SCAN_LAST);
    scan_d = wrap ? '0 : scan_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    lit    = ({1'b0, idx_q} < cnt_q);
    nib    = buf_q[{idx_q, 2'b00} +: 4];
    an_d   = lit ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d  = lit ? hex_seg : SEG_BLANK;
  end
  hex_a_7seg u_hex (.hex_i(nib), .seg_o(hex_seg));
  // Registered scan state and display drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= 4'hF;
      seg_q  <= SEG_BLANK;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end
  assign value       = value_q;
  assign value_valid = vv_q;
  assign digit_count = cnt_q;
  assign an          = an_q;
  assign seg         = seg_q;
endmodule

// File: tb/tb_captura_hex_display.sv
// tb_captura_hex_display: scoreboard bench with a digit-list reference model
module tb_captura_hex_display;
  logic        clk = 0, reset = 0, key_valid = 0;
  logic [3:0]  key_code = 0;
  logic [15:0] value;
  logic        value_valid;
  logic [2:0]  digit_count;
  logic [3:0]  an;
  logic [6:0]  seg;
  int errs = 0, checks = 0, cyc = 0;
  int digits[$];
  int exp_q[$];
  int last_val = 0;

  captura_hex_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .value(value), .value_valid(value_valid), .digit_count(digit_count),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= (!reset) ? 0 : cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int n);
    logic [6:0] hi;
    case (n)
      0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
      4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
      8: hi = 7'h7F;  9: hi = 7'h6F;  10: hi = 7'h77; 11: hi = 7'h7C;
      12: hi = 7'h39; 13: hi = 7'h5E; 14: hi = 7'h79; default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  task automatic model_key(input int c);
    int v;
    if (c == 14) digits.delete();
    else if (c == 15) begin
      if (digits.size() > 0) begin
        v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        exp_q.push_back(v);
        last_val = v;
        digits.delete();
      end
    end else if (digits.size() < 4) digits.push_back(c);
  endtask

  task automatic press(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1;
      key_code = 4'(c);
      model_key(c);
      @(negedge clk);
      chk("digit_count", int'(digit_count), digits.size());
      chk("value", int'(value), last_val);
    end
    key_valid = 0;
    key_code = 4'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic kv, input int c);
    reset = 0;
    key_valid = kv;
    key_code = 4'(c);
    @(negedge clk);
    reset = 1;
    key_valid = 0;
    digits.delete();
    last_val = 0;
    chk("rst_count", int'(digit_count), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_an", int'(an), 4'hF);
    chk("rst_seg", int'(seg), 7'h7F);
  endtask

  task automatic scan_check(input int n);
    int idx, k;
    logic [3:0] one;
    logic [3:0] ea;
    logic [6:0] es;
    one = 4'b0001;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = cyc;
      idx = ((k - 1) / 4) % 4;
      if (idx < digits.size()) begin
        ea = ~(one << idx);
        es = seg_ref(digits[digits.size() - 1 - idx]);
      end else begin
        ea = 4'hF;
        es = 7'h7F;
      end
      chk("scan_an", int'(an), int'(ea));
      chk("scan_seg", int'(seg), int'(es));
    end
  endtask

  initial begin
    int c;
    fork
      forever begin
        @(negedge clk);
        if (value_valid === 1'b1) begin
          if (exp_q.size() == 0) chk("unexpected_value_valid", 1, 0);
          else chk("committed_value", int'(value), exp_q.pop_front());
        end
      end
    join_none
    repeat (3) @(negedge clk);
    do_reset(1'b0, 0);
    chk("rst_valid", int'(value_valid), 0);
    press(1, 1); press(2, 1); press(3, 1); press(4, 1); press(15, 1);
    press(7, 1); press(10, 1); press(15, 1);
    press(5, 1); press(6, 1); press(7, 1); press(8, 1); press(9, 1); press(15, 1);
    press(3, 1); press(12, 1); press(14, 1); press(15, 1);
    press(5, 3); press(15, 1);
    do_reset(1'b0, 0);
    press(1, 1); press(2, 1);
    repeat (5) @(negedge clk);
    scan_check(40);
    press(9, 1); press(8, 1); press(7, 1);
    scan_check(20);
    do_reset(1'b1, 6);
    repeat (2) @(negedge clk);
    chk("post_rst_an", int'(an), 4'hF);
    for (int i = 0; i < 120; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 15);
      press(c, $urandom_range(1, 2));
      if (i % 20 == 19) scan_check(18);
    end
    press(15, 1);
    repeat (4) @(negedge clk);
    chk("pending_commits", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
